// File: rtl/handshaking_receiver_pkg.sv
// Shared definitions for the handshaking receiver: default widths and FSM state encoding.
package handshaking_receiver_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultDepth     = 4;
    localparam int unsigned DefaultAddrWidth = 2;

    // Occupancy classes of the receive buffer; encodings are fixed for debug visibility.
    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StPartial = 2'd1,
        StFull    = 2'd2
    } state_e;

endpackage

// File: rtl/handshaking_sync_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers and occupancy count.
// Callers guarantee push only when not full and pop only when not empty.
module handshaking_sync_fifo
    import handshaking_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned DEPTH      = DefaultDepth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CntOne = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    // Next-state pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; not reset since stale entries are never presented as valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/handshaking_receiver.sv
// Receiver end of a valid/ready word handshake, buffering accepted words in a
// first-word-fall-through FIFO for a local consumer that pops with rd_en.
module handshaking_receiver
    import handshaking_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned DEPTH      = DefaultDepth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  rd_err
);

    localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CntOne    = (ADDR_WIDTH + 1)'(1);

    state_e                state_q;
    logic                  data_ready_q;
    logic                  rd_err_q;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH:0]   count_d;
    logic [DATA_WIDTH-1:0] head;

    assign out_valid = (state_q != StEmpty);

    // Handshake qualification and next-state occupancy; push is blocked in FULL by
    // data_ready and pop is blocked in EMPTY by out_valid.
    always_comb begin
        push    = data_valid && data_ready_q;
        pop     = rd_en && out_valid;
        count_d = count;
        unique case ({push, pop})
            2'b10:   count_d = count + CntOne;
            2'b01:   count_d = count - CntOne;
            default: count_d = count;
        endcase
    end

    // Occupancy FSM with registered data_ready and sticky underflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            data_ready_q <= 1'b1;
            rd_err_q     <= 1'b0;
        end else begin
            data_ready_q <= (count_d != FullCount);
            case (state_q)
                StEmpty: begin
                    if (push)  state_q  <= StPartial;
                    if (rd_en) rd_err_q <= 1'b1;
                end
                StPartial: begin
                    if (count_d == '0)            state_q <= StEmpty;
                    else if (count_d == FullCount) state_q <= StFull;
                end
                StFull: begin
                    if (pop) state_q <= StPartial;
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    handshaking_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .rdata (head),
        .count (count)
    );

    // Gate the head so an empty buffer (including right after reset) reads as zero.
    assign data_out   = out_valid ? head : '0;
    assign data_ready = data_ready_q;
    assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_handshaking_receiver.sv
// Scoreboard bench for handshaking_receiver: a queue-based reference model tracks
// accepted words; a negedge monitor compares DUT outputs against it.
module tb_handshaking_receiver;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic [AW:0]   count;
    logic          rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_err;
    logic          m_push;
    logic          m_pop;

    handshaking_receiver #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .count      (count),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a bounded queue; acceptance uses occupancy before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            m_pop  = rd_en && (exp_q.size() > 0);
            m_push = data_valid && (exp_q.size() < DEPTH);
            if (rd_en && exp_q.size() == 0) exp_err = 1'b1;
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(data_in);
        end
    end

    // Monitor: compare flags every cycle and the head word whenever one is expected.
    always @(negedge clk) begin
        if (!rst) begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("data_ready", 32'(data_ready), 32'(exp_q.size() != DEPTH));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("rd_err", 32'(rd_err), 32'(exp_err));
            if (exp_q.size() != 0) check("data_out", 32'(data_out), 32'(exp_q[0]));
        end
    end

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
        data_valid = v;
        data_in    = d;
        rd_en      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_ready"}, 32'(data_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_rd_err"}, 32'(rd_err), 32'd0);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        rd_en      = 1'b0;
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);

        // Single word in and out
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Fill, stall with a held word, then free one slot
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
        repeat (3) cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b1, 8'h05, 1'b1);
        cycle(1'b1, 8'h05, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Simultaneous push and pop at count 2
        cycle(1'b1, 8'h31, 1'b0);
        cycle(1'b1, 8'h32, 1'b0);
        cycle(1'b1, 8'h77, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Stream across pointer wrap with alternate pops, then underflow
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 + i), 1'(i % 2));
        repeat (8) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("rd_err_sticky", 32'(rd_err), 32'd1);

        // Randomized traffic with varying pop pressure
        for (int i = 0; i < 400; i++) begin
            logic r;
            if (i < 130)      r = ($urandom_range(0, 3) == 0);
            else if (i < 260) r = ($urandom_range(0, 3) != 0);
            else              r = 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 1)), 8'($urandom), r);
        end

        // Reset asserted mid-cycle with data buffered
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle(1'b0, 8'h00, 1'b0);

        // Post-reset traffic
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        cycle(1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
